// File: rtl/aq_mode_pkg.sv
// ============================================================================
// Module   : aq_mode_pkg
// Brief    : Shared select codes, mode count and FSM state type for the
//            aquarium mode select encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aq_mode_pkg;

    localparam logic [4:0] SEL_IDLE  = 5'b00000;
    localparam logic [4:0] SEL_ERR   = 5'b11111;
    localparam int         NUM_MODES = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } aq_state_t;

endpackage : aq_mode_pkg

`default_nettype wire

// File: rtl/aq_onehot_enc.sv
// ============================================================================
// Module   : aq_onehot_enc
// Brief    : Combinational classifier/encoder for the 16-bit mode request.
//            AQ_PRIORITY_EN: multi-hot req[4:0] resolves to the lowest bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_onehot_enc
    import aq_mode_pkg::*;
(
    input  logic [15:0] i_req,
    output logic        o_legal,
    output logic        o_is_zero,
    output logic [3:0]  o_idx,
    output logic [4:0]  o_sel_code
);

    logic       w_upper_clr;
    logic       w_any_low;
    logic [3:0] w_low_idx;

    assign w_upper_clr = (i_req[15:NUM_MODES] == '0);
    assign w_any_low   = (i_req[NUM_MODES-1:0] != '0);
    assign o_is_zero   = (i_req == 16'h0000);

    // Descending scan so the lowest set bit is the one left standing.
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    assign o_idx      = w_low_idx;
    assign o_sel_code = w_any_low ? (5'b00001 << w_low_idx) : SEL_IDLE;

`ifdef AQ_PRIORITY_EN
    assign o_legal = w_upper_clr && w_any_low;
`else
    assign o_legal = w_upper_clr && $onehot(i_req[NUM_MODES-1:0]);
`endif

endmodule : aq_onehot_enc

`default_nettype wire

// File: rtl/aq_mode_select_encoder.sv
// ============================================================================
// Module   : aq_mode_select_encoder
// Brief    : Registers the mux select code for a one-hot mode request, holds
//            off new requests for MIN_DWELL cycles and traps illegal ones.
//            Build option AQ_PRIORITY_EN (see aq_onehot_enc).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aq_mode_select_encoder
    import aq_mode_pkg::*;
#(
    parameter int MIN_DWELL = 4,
    parameter int DWELL_W   = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      i_req,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_err_clr,
    output logic [4:0]       o_sel,
    output logic [3:0]       o_idx,
    output logic             o_sel_valid,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [DWELL_W-1:0] c_DWELL_LOAD =
        (MIN_DWELL > 0) ? DWELL_W'(MIN_DWELL - 1) : '0;

    aq_state_t          r_state,   w_state_nxt;
    logic [4:0]         r_sel,     w_sel_nxt;
    logic [3:0]         r_idx,     w_idx_nxt;
    logic               r_sel_vld, w_sel_vld_nxt;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic [DWELL_W-1:0] r_dwell,   w_dwell_nxt;

    logic       w_legal;
    logic       w_is_zero;
    logic [3:0] w_enc_idx;
    logic [4:0] w_enc_sel;
    logic       w_xfer;

    aq_onehot_enc u_enc (
        .i_req      (i_req),
        .o_legal    (w_legal),
        .o_is_zero  (w_is_zero),
        .o_idx      (w_enc_idx),
        .o_sel_code (w_enc_sel)
    );

    assign o_req_ready = (r_state == IDLE) || (r_state == ACTIVE);
    assign w_xfer      = i_req_valid && o_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= SEL_IDLE;
            r_idx     <= 4'd0;
            r_sel_vld <= 1'b0;
            r_err_cnt <= '0;
            r_dwell   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_idx     <= w_idx_nxt;
            r_sel_vld <= w_sel_vld_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_dwell   <= w_dwell_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_idx_nxt     = r_idx;
        w_sel_vld_nxt = 1'b0;
        w_err_cnt_nxt = r_err_cnt;
        w_dwell_nxt   = r_dwell;

        case (r_state)
            IDLE, ACTIVE: begin
                if (w_xfer) begin
                    w_sel_vld_nxt = 1'b1;
                    if (w_is_zero) begin
                        w_sel_nxt   = SEL_IDLE;
                        w_idx_nxt   = 4'd0;
                        w_state_nxt = IDLE;
                    end else if (w_legal) begin
                        w_sel_nxt = w_enc_sel;
                        w_idx_nxt = w_enc_idx;
                        if (MIN_DWELL > 0) begin
                            w_state_nxt = HOLD;
                            w_dwell_nxt = c_DWELL_LOAD;
                        end else begin
                            w_state_nxt = ACTIVE;
                        end
                    end else begin
                        // idx deliberately keeps the last accepted mode
                        w_sel_nxt   = SEL_ERR;
                        w_state_nxt = ERROR;
                        if (r_err_cnt != '1) begin
                            w_err_cnt_nxt = r_err_cnt + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (r_dwell == '0) begin
                    w_state_nxt = ACTIVE;
                end else begin
                    w_dwell_nxt = r_dwell - 1'b1;
                end
            end
            ERROR: begin
                if (i_err_clr) begin
                    w_sel_nxt   = SEL_IDLE;
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_sel       = r_sel;
    assign o_idx       = r_idx;
    assign o_sel_valid = r_sel_vld;
    assign o_err       = (r_state == ERROR);
    assign o_err_cnt   = r_err_cnt;

endmodule : aq_mode_select_encoder

`default_nettype wire

// File: tb/tb_aq_mode_select_encoder.sv
// ============================================================================
// Module   : tb_aq_mode_select_encoder
// Brief    : Directed self-checking bench for aq_mode_select_encoder
//            (MIN_DWELL=4); honours AQ_PRIORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aq_mode_select_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        req_valid;
    logic        req_ready;
    logic        err_clr;
    logic [4:0]  sel;
    logic [3:0]  idx;
    logic        sel_valid;
    logic        err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    aq_mode_select_encoder #(
        .MIN_DWELL (4),
        .DWELL_W   (4),
        .CNT_W     (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req       (req),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_err_clr   (err_clr),
        .o_sel       (sel),
        .o_idx       (idx),
        .o_sel_valid (sel_valid),
        .o_err       (err),
        .o_err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        req       = 16'h0000;
        req_valid = 1'b0;
        err_clr   = 1'b0;
        #12;
        check("rst_sel",   32'(sel),       32'h00);
        check("rst_idx",   32'(idx),       32'h0);
        check("rst_vld",   32'(sel_valid), 32'h0);
        check("rst_err",   32'(err),       32'h0);
        check("rst_cnt",   32'(err_cnt),   32'h00);
        check("rst_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        tick();

        // legal bit 2, ready low for exactly 4 cycles
        req = 16'h0004; req_valid = 1'b1;
        tick();
        req = 16'h0000; req_valid = 1'b0;
        check("t1_sel",   32'(sel),       32'h04);
        check("t1_idx",   32'(idx),       32'h2);
        check("t1_vld",   32'(sel_valid), 32'h1);
        check("t1_rdy0",  32'(req_ready), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_rdy_low", 32'(req_ready), 32'h0);
        end
        check("t1_vld_drop", 32'(sel_valid), 32'h0);
        tick();
        check("t1_rdy_back", 32'(req_ready), 32'h1);

        // repeat request restarts dwell; a new request held through HOLD
        req = 16'h0004; req_valid = 1'b1;
        tick();
        check("t2_rep_vld", 32'(sel_valid), 32'h1);
        check("t2_rep_sel", 32'(sel),       32'h04);
        check("t2_rep_rdy", 32'(req_ready), 32'h0);
        req = 16'h0010;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (sel_valid) begin
                n = i;
                break;
            end
            check("t2_stall_sel", 32'(sel), 32'h04);
        end
        req_valid = 1'b0;
        check("t2_accept_cycle", 32'(n), 32'd5);
        check("t2_sel", 32'(sel), 32'h10);
        check("t2_idx", 32'(idx), 32'h4);
        for (int i = 0; i < 4; i++) tick();
        check("t2_rdy", 32'(req_ready), 32'h1);

        // illegal upper bit, then clear wins over a simultaneous request
        req = 16'h0020; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t3_sel", 32'(sel),       32'h1F);
        check("t3_idx", 32'(idx),       32'h4);
        check("t3_err", 32'(err),       32'h1);
        check("t3_cnt", 32'(err_cnt),   32'h01);
        check("t3_rdy", 32'(req_ready), 32'h0);
        err_clr = 1'b1; req = 16'h0001; req_valid = 1'b1;
        tick();
        err_clr = 1'b0; req_valid = 1'b0; req = 16'h0000;
        check("t3_clr_sel", 32'(sel),       32'h00);
        check("t3_clr_idx", 32'(idx),       32'h0);
        check("t3_clr_err", 32'(err),       32'h0);
        check("t3_clr_rdy", 32'(req_ready), 32'h1);
        check("t3_clr_vld", 32'(sel_valid), 32'h0);
        tick();
        check("t3_dropped", 32'(sel), 32'h00);

        // err_clr outside ERROR is ignored; idle request returns to IDLE
        req = 16'h0002; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        err_clr = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        err_clr = 1'b0;
        check("t3b_sel", 32'(sel),       32'h02);
        check("t3b_rdy", 32'(req_ready), 32'h1);
        req = 16'h0000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t3b_idle_sel", 32'(sel),       32'h00);
        check("t3b_idle_idx", 32'(idx),       32'h0);
        check("t3b_idle_vld", 32'(sel_valid), 32'h1);
        check("t3b_idle_rdy", 32'(req_ready), 32'h1);

        // multi-hot low bits
        req = 16'h0003; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req = 16'h0000;
`ifdef AQ_PRIORITY_EN
        check("t4_sel", 32'(sel),     32'h01);
        check("t4_idx", 32'(idx),     32'h0);
        check("t4_err", 32'(err),     32'h0);
        check("t4_cnt", 32'(err_cnt), 32'h01);
        for (int i = 0; i < 4; i++) tick();
`else
        check("t4_sel", 32'(sel),     32'h1F);
        check("t4_err", 32'(err),     32'h1);
        check("t4_cnt", 32'(err_cnt), 32'h02);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
`endif
        check("t4_rdy", 32'(req_ready), 32'h1);

        // counter saturation
        for (int i = 0; i < 300; i++) begin
            req = 16'h8000; req_valid = 1'b1;
            tick();
            req_valid = 1'b0; err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
        end
        check("t5_cnt_sat", 32'(err_cnt), 32'hFF);
        req = 16'h0400; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t5_cnt_hold", 32'(err_cnt), 32'hFF);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // asynchronous reset mid-HOLD
        req = 16'h0008; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("t6_pre_rdy", 32'(req_ready), 32'h0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_sel", 32'(sel),       32'h00);
        check("t6_idx", 32'(idx),       32'h0);
        check("t6_rdy", 32'(req_ready), 32'h1);
        check("t6_cnt", 32'(err_cnt),   32'h00);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_aq_mode_select_encoder

`default_nettype wire
